// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: pin synchronizers, ps2_clk deglitch filter,
// 11-bit frame checker, and E0/F0 prefix folding into is_ext/is_break flags.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       new_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err,
    output logic [1:0] dbg_state
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FLT_W-1:0] flt_cnt;
    logic             clk_f, clk_f_d, fall;
    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             parity;
    logic [WD_W-1:0]  wd_cnt;
    logic             acc_vld, err_int;
    logic [7:0]       acc_byte;
    logic             ext_pend, brk_pend;

    // Both pins idle high, so the synchronizers reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // clk_f follows clk_s2 only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt <= '0;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fall    <= 1'b0;
        end else begin
            clk_f_d <= clk_f;
            fall    <= clk_f_d & ~clk_f;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Deframer; dat_s2 is the data bit whenever fall is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            parity   <= 1'b0;
            wd_cnt   <= '0;
            acc_vld  <= 1'b0;
            err_int  <= 1'b0;
            acc_byte <= 8'h00;
        end else begin
            acc_vld <= 1'b0;
            err_int <= 1'b0;
            if (state == IDLE) begin
                wd_cnt <= '0;
                if (fall && !dat_s2) begin
                    state   <= DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (fall) begin
                wd_cnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity <= dat_s2;
                        state  <= STOP;
                    end
                    STOP: begin
                        if ((^{shreg, parity}) && dat_s2) begin
                            acc_vld  <= 1'b1;
                            acc_byte <= shreg;
                        end else begin
                            err_int <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (wd_cnt == WD_LAST) begin
                err_int <= 1'b1;
                state   <= IDLE;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // new_code is a valid-only strobe: there is no ready, so the consumer must
    // capture scan_code/is_ext/is_break in the cycle new_code is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_code <= 8'h00;
            new_code  <= 1'b0;
            is_break  <= 1'b0;
            is_ext    <= 1'b0;
            frame_err <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            new_code  <= 1'b0;
            frame_err <= 1'b0;
            if (err_int) begin
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else if (acc_vld) begin
                if (acc_byte == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (acc_byte == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    scan_code <= acc_byte;
                    is_ext    <= ext_pend;
                    is_break  <= brk_pend;
                    new_code  <= 1'b1;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule
